// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between WB stage, multi-cycle unit, RegFile and the write-port arbiter.
// slave = arbiter side, master = requester/RegFile side.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy1;
  logic        busy2;
  logic        rf_regwrite;
  logic [4:0]  rf_writereg;
  logic [31:0] rf_writedata;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  iss_valid, iss_rd, rs1, rs2,
    input  rf_rdata1, rf_rdata2,
    output a_stall, b_ready, busy1, busy2,
    output rf_regwrite, rf_writereg, rf_writedata,
    output rdata1, rdata2
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output iss_valid, iss_rd, rs1, rs2,
    output rf_rdata1, rf_rdata2,
    input  a_stall, b_ready, busy1, busy2,
    input  rf_regwrite, rf_writereg, rf_writedata,
    input  rdata1, rdata2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between WB (A) and a multi-cycle unit (B), with
// starvation-forced B priority and a pending-write scoreboard. Option: RF_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      pend;
  logic [31:0]      pend_next;

  logic             grant_a;
  logic             grant_b;
  logic             wr_en;
  logic [4:0]       wr_rd;
  logic [31:0]      wr_data;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      FORCE_B: begin
        grant_b = bus.b_valid;
        grant_a = bus.a_valid & ~bus.b_valid;
      end
      default: begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid & ~bus.a_valid;
      end
    endcase
  end

  // rd=0 requests are granted so the handshake completes, but never written.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    if (grant_b) begin
      wr_en   = (bus.b_rd != 5'd0);
      wr_rd   = bus.b_rd;
      wr_data = bus.b_data;
    end else if (grant_a) begin
      wr_en   = (bus.a_rd != 5'd0);
      wr_rd   = bus.a_rd;
      wr_data = bus.a_data;
    end
  end

  always_comb begin
    cnt_next = starve_cnt;
    if (grant_b) begin
      cnt_next = '0;
    end else if (bus.b_valid && (starve_cnt != LIMIT)) begin
      cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // Set is applied after clear so a same-cycle issue of the committing rd stays pending.
  always_comb begin
    pend_next = pend;
    if (grant_b) begin
      pend_next[bus.b_rd] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      pend_next[bus.iss_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // FORCE_B is exactly starve_cnt==LIMIT; only a B grant clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      pend       <= '0;
    end else begin
      starve_cnt <= cnt_next;
      state      <= (cnt_next == LIMIT) ? FORCE_B : NORMAL;
      pend       <= pend_next;
    end
  end

  assign bus.a_stall      = bus.a_valid & ~grant_a;
  assign bus.b_ready      = grant_b;
  assign bus.rf_regwrite  = wr_en;
  assign bus.rf_writereg  = wr_rd;
  assign bus.rf_writedata = wr_data;
  assign bus.busy1        = pend[bus.rs1];
  assign bus.busy2        = pend[bus.rs2];

`ifdef RF_ARB_BYPASS_EN
  assign bus.rdata1 = (wr_en && (wr_rd == bus.rs1)) ? wr_data : bus.rf_rdata1;
  assign bus.rdata2 = (wr_en && (wr_rd == bus.rs2)) ? wr_data : bus.rf_rdata2;
`else
  assign bus.rdata1 = bus.rf_rdata1;
  assign bus.rdata2 = bus.rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expectations queued at drive time,
// popped and compared one time unit later, away from the rising edge.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          kind;
    logic [63:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [63:0] got;
  int          n_checks;
  int          n_fail;

  function automatic logic [63:0] ex(logic as, logic br, logic rw, logic [4:0] r,
                                     logic [31:0] d, logic b1, logic b2);
    return {22'd0, as, br, rw, r, d, b1, b2};
  endfunction

  function automatic logic [63:0] obs();
    return {22'd0, bus.a_stall, bus.b_ready, bus.rf_regwrite, bus.rf_writereg,
            bus.rf_writedata, bus.busy1, bus.busy2};
  endfunction

  task automatic push(string n, bit k, logic [63:0] v);
    exp_t t;
    t.name = n;
    t.kind = k;
    t.v    = v;
    exp_q.push_back(t);
  endtask

  task automatic drive(logic av, logic [4:0] ard, logic [31:0] ad,
                       logic bv, logic [4:0] brd, logic [31:0] bd,
                       logic iv, logic [4:0] ird);
    bus.a_valid   = av;
    bus.a_rd      = ard;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_rd      = brd;
    bus.b_data    = bd;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("reset_idle", 0, ex(0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(0, 0, 0, 1, 7, 32'h77, 0, 0);
    push("reset_b_only", 0, ex(0, 1, 1, 7, 32'h77, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
    push("reset_both", 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_idle_write();
    drive(1, 5, 32'hA5A5_0001, 0, 0, 0, 0, 0);
    push("idle_a_write", 0, ex(0, 0, 1, 5, 32'hA5A5_0001, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
    push("contend_a_wins", 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(0, 3, 32'h33, 1, 7, 32'h77, 0, 0);
    push("contend_b_alone", 0, ex(0, 1, 1, 7, 32'h77, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 5; i++) begin
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
      if (i < 4) push($sformatf("starve_lose%0d", i), 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
      else       push("starve_forced_b", 0, ex(1, 1, 1, 7, 32'h77, 0, 0));
      #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
      push($sformatf("starve_again%0d", i), 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
      #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      @(negedge clk);
    end
    drive(1, 3, 32'h33, 0, 7, 32'h77, 0, 0);
    push("forceb_a_served", 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
    push("forceb_kept", 0, ex(1, 1, 1, 7, 32'h77, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_scoreboard();
    logic [63:0] exps [8];
    exps[0] = ex(0, 0, 0, 0, 0, 0, 0);
    exps[1] = ex(0, 0, 0, 0, 0, 1, 0);
    exps[2] = ex(0, 1, 1, 9, 32'h99, 1, 0);
    exps[3] = ex(0, 0, 0, 0, 0, 0, 0);
    exps[4] = ex(0, 0, 0, 0, 0, 0, 0);
    exps[5] = ex(0, 1, 1, 9, 32'h98, 1, 0);
    exps[6] = ex(0, 0, 0, 0, 0, 1, 0);
    exps[7] = ex(0, 1, 1, 9, 32'h97, 1, 0);
    bus.rs1 = 5'd9;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 4:    drive(0, 0, 0, 0, 0, 0, 1, 9);
        2:       drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
        5:       drive(0, 0, 0, 1, 9, 32'h98, 1, 9);
        7:       drive(0, 0, 0, 1, 9, 32'h97, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      push($sformatf("sb_step%0d", i), 0, (i == 8) ? ex(0, 0, 0, 0, 0, 0, 0) : exps[i]);
      #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      @(negedge clk);
    end
    bus.rs1 = 5'd0;
  endtask

  task automatic test_x0();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
          push("x0_a_write", 0, ex(0, 0, 0, 0, 32'h1234, 0, 0));
        end
        1: begin
          drive(0, 0, 0, 1, 0, 32'h5678, 1, 0);
          push("x0_b_write", 0, ex(0, 1, 0, 0, 32'h5678, 0, 0));
        end
        default: begin
          drive(0, 0, 0, 0, 0, 0, 0, 0);
          push("x0_not_pending", 0, ex(0, 0, 0, 0, 0, 0, 0));
        end
      endcase
      #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] r2_hit;
    logic [31:0] r1_hit;
`ifdef RF_ARB_BYPASS_EN
    r2_hit = 32'hDEAD_BEEF;
    r1_hit = 32'hCAFE_0005;
`else
    r2_hit = 32'h2222_2222;
    r1_hit = 32'h1111_1111;
`endif
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd4;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1, 4, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
          push("byp_a_ctrl", 0, ex(0, 0, 1, 4, 32'hDEAD_BEEF, 0, 0));
          push("byp_a_rdata", 1, {32'h1111_1111, r2_hit});
        end
        1: begin
          drive(0, 0, 0, 1, 5, 32'hCAFE_0005, 0, 0);
          push("byp_b_ctrl", 0, ex(0, 1, 1, 5, 32'hCAFE_0005, 0, 0));
          push("byp_b_rdata", 1, {r1_hit, 32'h2222_2222});
        end
        default: begin
          drive(0, 0, 0, 0, 0, 0, 0, 0);
          push("byp_idle_ctrl", 0, ex(0, 0, 0, 0, 0, 0, 0));
          push("byp_idle_rdata", 1, {32'h1111_1111, 32'h2222_2222});
        end
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        got = e.kind ? {bus.rdata1, bus.rdata2} : obs();
        n_checks++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      end
      @(negedge clk);
    end
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
  endtask

  task automatic test_reset_mid_forceb();
    bus.rs1 = 5'd12;
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 32'h33, 1, 7, 32'h77, 0, 0);
      push($sformatf("rmid_lose%0d", i), 0, ex(0, 0, 1, 3, 32'h33, 1, 0));
      #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
      @(negedge clk);
    end
    push("rmid_forceb", 0, ex(1, 1, 1, 7, 32'h77, 1, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    #1 rst = 1'b1;
    push("rmid_async_clear", 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    rst = 1'b0;
    push("rmid_after_normal", 0, ex(0, 0, 1, 3, 32'h33, 0, 0));
    #1;
    e = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, got, e.v); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.rs1 = 5'd0;
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.rs1       = 5'd0;
    bus.rs2       = 5'd0;
    bus.rf_rdata1 = 32'h1111_1111;
    bus.rf_rdata2 = 32'h2222_2222;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_idle_write();
    test_contention();
    test_starvation();
    test_scoreboard();
    test_x0();
    test_bypass();
    test_reset_mid_forceb();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
